// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM states and default latencies.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MC_BUSY  = 2'd2
  } hz_state_e;

  localparam int LOAD_LAT_DEF = 1;
  localparam int MC_LAT_DEF   = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hit detector: EX-stage load destination matches a live ID-stage source.
module hazard_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  input  logic              mem_read_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              hit_o
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hit_o = mem_read_i && (rd_i != '0) &&
                 ((use_rs1_i && (rs1_i == rd_i)) || (use_rs2_i && (rs2_i == rd_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle EX holds, branch flushes,
// and a saturating stalled-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int MC_LAT   = MC_LAT_DEF,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic              if_id_use_rs1,
  input  logic              if_id_use_rs2,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_mc_start,
  input  logic              ex_branch_taken,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_hold,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam int CNT_W = $clog2(max2(LOAD_LAT, MC_LAT) + 1);
  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] MC_INIT = CNT_W'(MC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hz_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_cnt_q;
  logic              hit;
  logic              pc_stall_d, if_id_stall_d, if_id_flush_d, id_ex_flush_d, ex_hold_d;

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
    .rs1_i      (if_id_rs1),
    .rs2_i      (if_id_rs2),
    .use_rs1_i  (if_id_use_rs1),
    .use_rs2_i  (if_id_use_rs2),
    .mem_read_i (id_ex_mem_read),
    .rd_i       (id_ex_rd),
    .hit_o      (hit)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_stall_d    = 1'b0;
    if_id_stall_d = 1'b0;
    if_id_flush_d = 1'b0;
    id_ex_flush_d = 1'b0;
    ex_hold_d     = 1'b0;
    case (state_q)
      MC_BUSY: begin
        // EX is frozen, so a branch outcome seen now is not yet real
        pc_stall_d    = 1'b1;
        if_id_stall_d = 1'b1;
        ex_hold_d     = 1'b1;
        cnt_d         = cnt_q - 1'b1;
        if (cnt_q == CNT_ONE) state_d = RUN;
      end
      LD_STALL: begin
        if (ex_branch_taken) begin
          if_id_flush_d = 1'b1;
          id_ex_flush_d = 1'b1;
          cnt_d         = '0;
          state_d       = RUN;
        end else begin
          pc_stall_d    = 1'b1;
          if_id_stall_d = 1'b1;
          id_ex_flush_d = 1'b1;
          cnt_d         = cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) state_d = RUN;
        end
      end
      default: begin
        if (ex_branch_taken) begin
          if_id_flush_d = 1'b1;
          id_ex_flush_d = 1'b1;
        end else if (id_ex_mc_start) begin
          pc_stall_d    = 1'b1;
          if_id_stall_d = 1'b1;
          ex_hold_d     = 1'b1;
          if (MC_LAT > 1) begin
            state_d = MC_BUSY;
            cnt_d   = MC_INIT;
          end
        end else if (hit) begin
          pc_stall_d    = 1'b1;
          if_id_stall_d = 1'b1;
          id_ex_flush_d = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LD_STALL;
            cnt_d   = LD_INIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall_d && (stall_cnt_q != {PERF_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // Combinational paths from inputs must also be silenced while reset is held
  assign pc_stall    = rst_n & pc_stall_d;
  assign if_id_stall = rst_n & if_id_stall_d;
  assign if_id_flush = rst_n & if_id_flush_d;
  assign id_ex_flush = rst_n & id_ex_flush_d;
  assign ex_hold     = rst_n & ex_hold_d;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations driven in parallel, checked against
// a remaining-cycles model every cycle plus hand-computed scenario expectations.
module tb_hazard_ctrl;

  localparam int LA = 1, MA = 4, PA = 16;
  localparam int LB = 3, MB = 1, PB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       use1, use2, mem_read, mc, br;

  logic        pcA, ifsA, iffA, exfA, hA;
  logic [15:0] scA;
  logic        pcB, ifsB, iffB, exfB, hB;
  logic [3:0]  scB;

  int checks = 0;
  int errors = 0;
  int ld_rem[2], mc_rem[2], cnt[2];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(LA), .MC_LAT(MA), .PERF_W(PA)) dutA (
    .clk(clk), .rst_n(rst_n), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_use_rs1(use1), .if_id_use_rs2(use2), .id_ex_mem_read(mem_read),
    .id_ex_rd(rd), .id_ex_mc_start(mc), .ex_branch_taken(br),
    .pc_stall(pcA), .if_id_stall(ifsA), .if_id_flush(iffA), .id_ex_flush(exfA),
    .ex_hold(hA), .stall_cnt(scA));

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(LB), .MC_LAT(MB), .PERF_W(PB)) dutB (
    .clk(clk), .rst_n(rst_n), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_use_rs1(use1), .if_id_use_rs2(use2), .id_ex_mem_read(mem_read),
    .id_ex_rd(rd), .id_ex_mc_start(mc), .ex_branch_taken(br),
    .pc_stall(pcB), .if_id_stall(ifsB), .if_id_flush(iffB), .id_ex_flush(exfB),
    .ex_hold(hB), .stall_cnt(scB));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  // Model: outputs follow from how many stall/hold cycles are still owed.
  always @(negedge clk) begin
    logic [4:0] got, e;
    logic [31:0] gcnt;
    bit hit;
    int L, M, mx;
    hit = mem_read && rd != 0 && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    for (int k = 0; k < 2; k++) begin
      got  = k ? {pcB, ifsB, iffB, exfB, hB} : {pcA, ifsA, iffA, exfA, hA};
      gcnt = k ? 32'(scB) : 32'(scA);
      L    = k ? LB : LA;
      M    = k ? MB : MA;
      mx   = k ? (1 << PB) - 1 : (1 << PA) - 1;
      if (!rst_n) begin
        ld_rem[k] = 0; mc_rem[k] = 0; cnt[k] = 0; e = 5'b0;
      end else if (mc_rem[k] > 0) begin
        e = 5'b11001; mc_rem[k]--;
      end else if (br) begin
        e = 5'b00110; ld_rem[k] = 0;
      end else if (ld_rem[k] > 0) begin
        e = 5'b11010; ld_rem[k]--;
      end else if (mc) begin
        e = 5'b11001; mc_rem[k] = M - 1;
      end else if (hit) begin
        e = 5'b11010; ld_rem[k] = L - 1;
      end else begin
        e = 5'b0;
      end
      chk(k ? "outs_B" : "outs_A", 32'(got), 32'(e));
      chk(k ? "stall_cnt_B" : "stall_cnt_A", gcnt, 32'(cnt[k]));
      if (rst_n && e[4] && cnt[k] < mx) cnt[k]++;
    end
  end

  task automatic idle();
    mem_read = 0; rd = 0; rs1 = 0; rs2 = 0; use1 = 0; use2 = 0; mc = 0; br = 0;
  endtask
  task automatic hitset(input logic [4:0] r);
    mem_read = 1; rd = r; rs1 = r; use1 = 1;
  endtask
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); #1; endtask

  initial begin
    rst_n = 0;
    idle(); hitset(5); mc = 1; br = 1;
    smp();
    chk("rst_outs_A", 32'({pcA, ifsA, iffA, exfA, hA}), 0);
    chk("rst_outs_B", 32'({pcB, ifsB, iffB, exfB, hB}), 0);
    chk("rst_cnt_A", 32'(scA), 0);
    idle();
    #2 rst_n = 1;
    cyc(); cyc();

    // load-use with LOAD_LAT=1 on A
    hitset(5); smp();
    chk("s1_pc_A", 32'(pcA), 1); chk("s1_exf_A", 32'(exfA), 1);
    cyc(); idle(); smp();
    chk("s1_end_A", 32'(pcA), 0); chk("s1_cnt_A", 32'(scA), 1);
    repeat (3) cyc();

    // LOAD_LAT=3 on B, then a hit on x0
    hitset(5); smp(); chk("s2_pc_B0", 32'(pcB), 1);
    cyc(); idle();
    for (int i = 1; i < 4; i++) begin
      smp(); chk("s2_pc_B", 32'(pcB), 32'(i < 3)); cyc();
    end
    hitset(0); smp();
    chk("s2_x0_A", 32'(pcA), 0); chk("s2_x0_B", 32'(pcB), 0);
    chk("s2_cnt_B", 32'(scB), 6);
    cyc(); idle();

    // multi-cycle hold on A, branch during hold ignored
    mc = 1; smp(); chk("s3_hold_A0", 32'({hA, pcA}), 3);
    cyc(); mc = 0;
    for (int i = 1; i < 5; i++) begin
      br = (i == 2); smp();
      chk("s3_hold_A", 32'(hA), 32'(i < 4)); chk("s3_pc_A", 32'(pcA), 32'(i < 4));
      chk("s3_exf_A", 32'(exfA), 0); chk("s3_iff_A", 32'(iffA), 0);
      cyc();
    end
    br = 0;

    // branch in the 2nd load-stall cycle on B
    hitset(5); smp(); chk("s4_pc_B0", 32'(pcB), 1);
    cyc(); idle(); br = 1; smp();
    chk("s4_flush_B", 32'({iffB, exfB}), 3); chk("s4_stall_B", 32'({pcB, ifsB}), 0);
    cyc(); br = 0; smp();
    chk("s4_run_B", 32'({pcB, ifsB, iffB, exfB, hB}), 0);
    cyc();

    // reset in the 2nd MC_BUSY cycle on A
    mc = 1; smp(); cyc(); mc = 0; smp(); cyc(); smp();
    chk("s5_busy_A", 32'(hA), 1);
    #2 rst_n = 0; #1;
    chk("s5_async_A", 32'({pcA, ifsA, iffA, exfA, hA}), 0);
    chk("s5_async_B", 32'({pcB, ifsB, iffB, exfB, hB}), 0);
    chk("s5_cnt_A", 32'(scA), 0); chk("s5_cnt_B", 32'(scB), 0);
    @(negedge clk); #2 rst_n = 1;
    cyc(); hitset(5); smp();
    chk("s5_hit_A", 32'({pcA, exfA}), 3);
    cyc(); idle(); smp();
    chk("s5_end_A", 32'(pcA), 0); chk("s5_cnt1_A", 32'(scA), 1);

    // saturation of the 4-bit counter on B
    cyc(); hitset(5);
    repeat (20) cyc();
    idle(); smp();
    chk("s6_sat_B", 32'(scB), 15);
    cyc();

    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      rd       = 5'($urandom_range(0, 3));
      use1     = 1'($urandom);
      use2     = 1'($urandom);
      mem_read = 1'($urandom);
      mc       = ($urandom_range(0, 7) == 0);
      br       = ($urandom_range(0, 7) == 0);
      cyc();
    end
    rst_n = 1; idle();
    smp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
